// File: rtl/cathode_top_decoder.sv
// Registered hex-to-seven-segment cathode decoder for one display digit.
// Output bit order is {DP,G,F,E,D,C,B,A}; polarity and decimal point are fixed by parameters.
module cathode_top_decoder #(
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit DP_ON      = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] encoded,
    output logic [7:0] segments
);

    localparam logic [7:0] DARK = ACTIVE_LOW ? '1 : '0;

    logic [7:0] pattern_al;
    logic       code_valid;
    logic [7:0] segments_next;

    // Base patterns are active-low with DP dark; DP and polarity are applied afterwards.
    always_comb begin
        pattern_al = '1;
        code_valid = 1'b1;
        case (encoded)
            4'h0:    pattern_al = 8'hC0;
            4'h1:    pattern_al = 8'hF9;
            4'h2:    pattern_al = 8'hA4;
            4'h3:    pattern_al = 8'hB0;
            4'h4:    pattern_al = 8'h99;
            4'h5:    pattern_al = 8'h92;
            4'h6:    pattern_al = 8'h82;
            4'h7:    pattern_al = 8'hF8;
            4'h8:    pattern_al = 8'h80;
            4'h9:    pattern_al = 8'h90;
            4'hA:    pattern_al = 8'h88;
            4'hB:    pattern_al = 8'h83;
            4'hC:    pattern_al = 8'hC6;
            4'hD:    pattern_al = 8'hA1;
            4'hE:    pattern_al = 8'h86;
            4'hF:    pattern_al = 8'h8E;
            // Only reachable with X/Z on encoded in simulation.
            default: code_valid = 1'b0;
        endcase
    end

    always_comb begin
        segments_next = pattern_al;
        if (DP_ON) begin
            segments_next[7] = 1'b0;
        end
        if (!ACTIVE_LOW) begin
            segments_next = ~segments_next;
        end
        if (!code_valid) begin
            segments_next = DARK;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            segments <= DARK;
        end else begin
            segments <= segments_next;
        end
    end

endmodule

// File: tb/tb_cathode_top_decoder.sv
// Scoreboard bench for cathode_top_decoder: three parameter variants share one stimulus stream.
module tb_cathode_top_decoder;

    logic       clk;
    logic       clk_en;
    logic       reset;
    logic [3:0] encoded;
    logic [7:0] seg_def;
    logic [7:0] seg_ah;
    logic [7:0] seg_dp;

    int unsigned n_checks;
    int unsigned n_fail;

    logic [3:0] sb [$];
    logic [7:0] tbl [16];

    cathode_top_decoder #(.ACTIVE_LOW(1'b1), .DP_ON(1'b0)) dut_def (
        .clk(clk), .reset(reset), .encoded(encoded), .segments(seg_def)
    );
    cathode_top_decoder #(.ACTIVE_LOW(1'b0), .DP_ON(1'b0)) dut_ah (
        .clk(clk), .reset(reset), .encoded(encoded), .segments(seg_ah)
    );
    cathode_top_decoder #(.ACTIVE_LOW(1'b1), .DP_ON(1'b1)) dut_dp (
        .clk(clk), .reset(reset), .encoded(encoded), .segments(seg_dp)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_dark(input string tag);
        check({tag, "_def"}, seg_def, 8'hFF);
        check({tag, "_ah"},  seg_ah,  8'h00);
        check({tag, "_dp"},  seg_dp,  8'hFF);
    endtask

    // Drive a nibble and queue its expected decode; no clock wait.
    task automatic drive(input logic [3:0] e);
        encoded = e;
        sb.push_back(e);
    endtask

    // Wait for the loading edge, then pop one expectation and compare all variants.
    task automatic expect_edge(input string tag);
        logic [3:0] e;
        logic [7:0] al;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 8'h01, 8'h00);
        end else begin
            e  = sb.pop_front();
            al = tbl[e];
            check({tag, "_def"}, seg_def, al);
            check({tag, "_ah"},  seg_ah,  ~al);
            check({tag, "_dp"},  seg_dp,  al & 8'h7F);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] e);
        @(negedge clk);
        drive(e);
        expect_edge(tag);
    endtask

    initial begin
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        n_checks = 0;
        n_fail   = 0;
        clk_en   = 1'b0;
        reset    = 1'b0;
        encoded  = 4'h3;

        // Reset with the clock stopped must darken immediately.
        #2;
        reset = 1'b1;
        #1;
        check_dark("rst_noclk");
        #10;
        reset = 1'b0;
        drive(4'h0);
        #1;
        check_dark("rst_release_hold");
        clk_en = 1'b1;
        expect_edge("first_edge");

        // Sweep every code, one per cycle.
        for (int unsigned i = 0; i < 16; i++) begin
            step("sweep", 4'(i));
        end

        // Held input: value stays put mid-cycle as well as after edges.
        for (int unsigned i = 0; i < 20; i++) begin
            step("hold", 4'h8);
            #3;
            check("hold_mid", seg_def, 8'h80);
        end

        // Async reset between edges, then reload on the first edge after release.
        step("pre_rst", 4'h5);
        #1;
        reset = 1'b1;
        #1;
        check_dark("rst_mid");
        @(posedge clk);
        #1;
        check_dark("rst_held_edge");
        @(negedge clk);
        reset = 1'b0;
        drive(4'h5);
        expect_edge("post_rst");

        // Random back-to-back traffic.
        for (int unsigned i = 0; i < 40; i++) begin
            step("rand", 4'($urandom_range(0, 15)));
        end

        check("sb_drained", 8'(sb.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
